fb_port_arbiter: RTL
====================

// Module: fb_port_arbiter
// PURPOSE
//  Shares the single-port, synchronous-read video memory between two users:
//  the VGA scan-out address generator (read-only, hard real-time) and the GPU
//  command side (reads/writes, valid/ready).
//  VGA scan-out always owns the port on its read slot. The GPU is serviced in
//  all remaining cycles through a small write FIFO plus one pending-read slot.
//  The block sits between the address generator, the GPU core and the memory macro.
// PARAMETERS
//  ADDR_W      12  memory word address width (4096 words)
//  DATA_W       8  memory word width
//  FIFO_DEPTH   4  GPU write FIFO entries; power of 2, >=2
//  STALL_W     16  width of the saturating GPU stall counter
// PORTS
//  clock           in   1        system clock; all logic on posedge
//  reset           in   1        synchronous, active-high
//  vga_clock       in   1        pixel phase enable; toggles every clock
//  video_on        in   1        scan-out active
//  vga_addr        in   ADDR_W   scan-out read address
//  vga_data        out  DATA_W   registered scan-out read data
//  vga_data_valid  out  1        1-cycle pulse: vga_data updated
//  gpu_valid       in   1        GPU request valid
//  gpu_ready       out  1        GPU request accepted when valid&ready
//  gpu_we          in   1        1 = write, 0 = read
//  gpu_addr        in   ADDR_W   GPU address
//  gpu_wdata       in   DATA_W   GPU write data
//  gpu_rdata       out  DATA_W   GPU read data
//  gpu_rvalid      out  1        1-cycle pulse: gpu_rdata valid
//  mem_addr        out  ADDR_W   memory address (combinational from slot decision)
//  mem_we          out  1        memory write enable
//  mem_wdata       out  DATA_W   memory write data
//  mem_rdata       in   DATA_W   memory read data, valid 1 cycle after address
//  stall_cnt       out  STALL_W  cycles with gpu_valid & ~gpu_ready; saturates
// BEHAVIOUR
//  Reset: all registered outputs 0; FIFO emptied; rd_pend/rd_infl cleared;
//   stall_cnt = 0. Requests in flight are discarded (no mem_we after reset).
//  Slot priority, evaluated each cycle:
//   1. VGA slot (vga_clock & video_on): mem_addr = vga_addr, mem_we = 0.
//   2. else FIFO non-empty: pop head; mem_addr/mem_wdata = head; mem_we = 1.
//   3. else rd_pend: mem_addr = pending addr, mem_we = 0; rd_pend clears,
//      rd_infl sets.
//   4. else idle: mem_we = 0, mem_addr = 0.
//  Read latency: the cycle after a VGA slot, vga_data <= mem_rdata and
//   vga_data_valid = 1. The cycle after a GPU read issue, gpu_rdata <= mem_rdata,
//   gpu_rvalid = 1, rd_infl clears. vga_data/gpu_rdata hold between updates.
//  Handshake:
//   - gpu_ready = ~full & ~rd_pend & ~rd_infl; it does not depend on gpu_we
//     or gpu_valid.
//   - Accepted write: push {addr, wdata}. Accepted read: latch addr, set rd_pend.
//   - A read issues only after the FIFO is empty, so reads see every earlier write.
//   - Push and pop in the same cycle: count unchanged. Push when full cannot
//     occur (ready = 0).
//   - An entry pushed in cycle N can pop in cycle N+1 at the earliest.
//  FIFO: circular, pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
//  Bandwidth: the VGA is never refused. During active video the GPU gets
//   1 cycle in 2; during blanking it gets every cycle.
//  stall_cnt: +1 per cycle with gpu_valid & ~gpu_ready; holds at 2^STALL_W-1.
// TESTING
//  T1 Reset: reset=1 for 2 cycles, then 0 -> all outputs 0, gpu_ready=1,
//     mem_we=0.
//  T2 Blanking burst: video_on=0; writes 0x000..0x003 <- 0xA0..0xA3 on
//     consecutive cycles -> mem_we=1 one cycle after each accept, same order
//     and data; gpu_ready never drops.
//  T3 Scan-out: video_on=1, vga_clock toggling, vga_addr=0x040,
//     mem_rdata=0x3C -> mem_addr=0x040, mem_we=0 on every vga_clock=1 cycle;
//     vga_data=0x3C, vga_data_valid=1 the next cycle; GPU writes appear only
//     on vga_clock=0 cycles.
//  T4 FIFO full: video_on=1; 6 back-to-back writes -> gpu_ready=0 once
//     count=4; stall_cnt counts the stalled cycles exactly; all 6 writes
//     reach memory in order.
//  T5 Read-after-write: write 0x123 <- 0x5A, then read 0x123 -> the write
//     issues before the read on the mem port; gpu_rvalid=1 with
//     gpu_rdata=0x5A; gpu_ready=0 until gpu_rvalid.
//  T6 Reset mid-op: 3 entries queued with video_on=1, assert reset 1 cycle
//     -> no mem_we from the reset cycle onward; gpu_ready=1 after; no
//     gpu_rvalid.

Source files
------------

// File: rtl/fb_port_arbiter_if.sv
// GPU command-side handshake bundle: valid/ready request channel plus
// the registered read-return pulse.
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              gpu_valid;
    logic              gpu_ready;
    logic              gpu_we;
    logic [ADDR_W-1:0] gpu_addr;
    logic [DATA_W-1:0] gpu_wdata;
    logic [DATA_W-1:0] gpu_rdata;
    logic              gpu_rvalid;

    modport master (
        output gpu_valid, gpu_we, gpu_addr, gpu_wdata,
        input  gpu_ready, gpu_rdata, gpu_rvalid
    );

    modport slave (
        input  gpu_valid, gpu_we, gpu_addr, gpu_wdata,
        output gpu_ready, gpu_rdata, gpu_rvalid
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port video memory arbiter: VGA scan-out owns its read slot, the GPU
// uses every other cycle through a write FIFO and one pending-read slot.
module fb_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STALL_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               vga_clock,
    input  logic               video_on,
    input  logic [ADDR_W-1:0]  vga_addr,
    output logic [DATA_W-1:0]  vga_data,
    output logic               vga_data_valid,
    fb_port_arbiter_if.slave   gpu,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [STALL_W-1:0] stall_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_VGA,
        SLOT_WRITE,
        SLOT_READ
    } slot_t;

    slot_t             slot;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              full;
    logic              rd_pend;
    logic              rd_infl;
    logic [ADDR_W-1:0] rd_addr;
    logic              vga_pend;
    logic              push;
    logic              pop;
    logic              rd_accept;

    assign full          = (count == DEPTH_C);
    assign gpu.gpu_ready = ~full & ~rd_pend & ~rd_infl;
    assign push          = gpu.gpu_valid & gpu.gpu_ready & gpu.gpu_we;
    assign rd_accept     = gpu.gpu_valid & gpu.gpu_ready & ~gpu.gpu_we;
    assign pop           = (slot == SLOT_WRITE);

    // Reset forces the idle slot so a queued write cannot reach memory while
    // the FIFO is being flushed.
    always_comb begin
        slot = SLOT_IDLE;
        if (!reset) begin
            if (vga_clock && video_on)
                slot = SLOT_VGA;
            else if (count != '0)
                slot = SLOT_WRITE;
            else if (rd_pend)
                slot = SLOT_READ;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (slot)
            SLOT_VGA:   mem_addr = vga_addr;
            SLOT_WRITE: begin
                mem_addr  = fifo_addr[rd_ptr];
                mem_wdata = fifo_data[rd_ptr];
                mem_we    = 1'b1;
            end
            SLOT_READ:  mem_addr = rd_addr;
            default:    ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= gpu.gpu_addr;
            fifo_data[wr_ptr] <= gpu.gpu_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            rd_pend        <= 1'b0;
            rd_infl        <= 1'b0;
            rd_addr        <= '0;
            vga_pend       <= 1'b0;
            vga_data       <= '0;
            vga_data_valid <= 1'b0;
            gpu.gpu_rdata  <= '0;
            gpu.gpu_rvalid <= 1'b0;
            stall_cnt      <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            if (rd_accept) begin
                rd_pend <= 1'b1;
                rd_addr <= gpu.gpu_addr;
            end else if (slot == SLOT_READ) begin
                rd_pend <= 1'b0;
            end

            // Memory data lags the address by one cycle, so capture is one
            // stage behind the slot that issued it.
            rd_infl        <= (slot == SLOT_READ);
            gpu.gpu_rvalid <= rd_infl;
            if (rd_infl)
                gpu.gpu_rdata <= mem_rdata;

            vga_pend       <= (slot == SLOT_VGA);
            vga_data_valid <= vga_pend;
            if (vga_pend)
                vga_data <= mem_rdata;

            if (gpu.gpu_valid && !gpu.gpu_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule
